// File: rtl/prog_seq_ctrl.sv
// Program sequencer for a small core: launches programs 1..3 in rotation,
// captures divisor bytes, and traps divide-by-zero and watchdog faults.
module prog_seq_ctrl #(
   parameter logic [15:0] TIMEOUT = 16'd50000
) (
   input  logic       CLK,
   input  logic       Reset,
   input  logic       Start,
   input  logic       Ack,
   input  logic [8:0] Instruction,
   input  logic [7:0] DataIn,
   input  logic [9:0] PC,
   output logic [1:0] ProgState,
   output logic       CoreReset,
   output logic       Busy,
   output logic       Done,
   output logic       Halt,
   output logic       DivZero,
   output logic       Timeout,
   output logic [7:0] divisor_msb,
   output logic [7:0] divisor_lsb
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_RUN,
      S_DONE,
      S_FAULT
   } state_t;

   localparam logic [15:0] TIMEOUT_LAST = TIMEOUT - 16'd1;

   state_t      state_reg, state_next;
   logic [1:0]  prog_reg, prog_next;
   logic [7:0]  msb_reg, msb_next;
   logic [7:0]  lsb_reg, lsb_next;
   logic [15:0] count_reg, count_next;
   logic        div_zero_reg, div_zero_next;
   logic        timeout_reg, timeout_next;
   logic        core_reset_reg, busy_reg, done_reg, halt_reg;
   logic        zero_hit;

   // Zero check looks at divisor registers as held before this edge.
   always_comb begin
      zero_hit = 1'b0;
      if (prog_reg == 2'b01 && PC == 10'h02C && {msb_reg, lsb_reg} == 16'h0000)
         zero_hit = 1'b1;
      if (prog_reg == 2'b10 && PC == 10'h067 && msb_reg == 8'h00)
         zero_hit = 1'b1;
   end

   always_comb begin
      state_next    = state_reg;
      prog_next     = prog_reg;
      msb_next      = msb_reg;
      lsb_next      = lsb_reg;
      count_next    = count_reg;
      div_zero_next = div_zero_reg;
      timeout_next  = timeout_reg;
      case (state_reg)
         S_IDLE: begin
            if (Start) begin
               prog_next  = (prog_reg == 2'b11) ? 2'b01 : prog_reg + 2'b01;
               state_next = S_INIT;
            end
         end
         S_INIT: begin
            msb_next   = 8'h00;
            lsb_next   = 8'h00;
            count_next = 16'h0000;
            state_next = S_RUN;
         end
         S_RUN: begin
            if (count_reg != 16'hFFFF)
               count_next = count_reg + 16'd1;
            case (prog_reg)
               2'b01: begin
                  if (Instruction == 9'h007)
                     msb_next = DataIn;
                  else if (Instruction == 9'h00F)
                     lsb_next = DataIn;
               end
               2'b10: begin
                  if (Instruction == 9'h017)
                     msb_next = DataIn;
                  lsb_next = 8'h00;
               end
               default: ;
            endcase
            if (zero_hit) begin
               div_zero_next = 1'b1;
               state_next    = S_FAULT;
            end else if (Ack) begin
               state_next = S_DONE;
            end else if (count_reg == TIMEOUT_LAST) begin
               timeout_next = 1'b1;
               state_next   = S_FAULT;
            end
         end
         S_DONE: state_next = S_IDLE;
         S_FAULT: begin
            if (Start) begin
               div_zero_next = 1'b0;
               timeout_next  = 1'b0;
               state_next    = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Status outputs are decoded from the next state so they line up with it.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_reg      <= S_IDLE;
         prog_reg       <= 2'b00;
         msb_reg        <= 8'h00;
         lsb_reg        <= 8'h00;
         count_reg      <= 16'h0000;
         div_zero_reg   <= 1'b0;
         timeout_reg    <= 1'b0;
         core_reset_reg <= 1'b0;
         busy_reg       <= 1'b0;
         done_reg       <= 1'b0;
         halt_reg       <= 1'b0;
      end else begin
         state_reg      <= state_next;
         prog_reg       <= prog_next;
         msb_reg        <= msb_next;
         lsb_reg        <= lsb_next;
         count_reg      <= count_next;
         div_zero_reg   <= div_zero_next;
         timeout_reg    <= timeout_next;
         core_reset_reg <= (state_next == S_INIT);
         busy_reg       <= (state_next == S_INIT) || (state_next == S_RUN);
         done_reg       <= (state_next == S_DONE);
         halt_reg       <= (state_next == S_FAULT);
      end
   end

   assign ProgState   = prog_reg;
   assign CoreReset   = core_reset_reg;
   assign Busy        = busy_reg;
   assign Done        = done_reg;
   assign Halt        = halt_reg;
   assign DivZero     = div_zero_reg;
   assign Timeout     = timeout_reg;
   assign divisor_msb = msb_reg;
   assign divisor_lsb = lsb_reg;

endmodule

// File: tb/tb_prog_seq_ctrl.sv
// Directed bench for prog_seq_ctrl with a short watchdog (TIMEOUT=8).
module tb_prog_seq_ctrl;

   logic       CLK = 1'b0;
   logic       Reset = 1'b1;
   logic       Start = 1'b0;
   logic       Ack = 1'b0;
   logic [8:0] Instruction = 9'h000;
   logic [7:0] DataIn = 8'h00;
   logic [9:0] PC = 10'h000;
   logic [1:0] ProgState;
   logic       CoreReset, Busy, Done, Halt, DivZero, Timeout;
   logic [7:0] divisor_msb, divisor_lsb;

   int errors = 0;
   int checks = 0;

   prog_seq_ctrl #(.TIMEOUT(16'd8)) dut (
      .CLK(CLK), .Reset(Reset), .Start(Start), .Ack(Ack),
      .Instruction(Instruction), .DataIn(DataIn), .PC(PC),
      .ProgState(ProgState), .CoreReset(CoreReset), .Busy(Busy),
      .Done(Done), .Halt(Halt), .DivZero(DivZero), .Timeout(Timeout),
      .divisor_msb(divisor_msb), .divisor_lsb(divisor_lsb)
   );

   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Packs every output into one word: {prog,cr,busy,done,halt,dz,to,msb,lsb}
   function automatic logic [23:0] outs();
      return {ProgState, CoreReset, Busy, Done, Halt, DivZero, Timeout, divisor_msb, divisor_lsb};
   endfunction

   task automatic test_reset();
      Reset = 1'b1;
      step();
      step();
      checks++;
      if (outs() !== 24'h0) begin
         errors++;
         $display("FAIL reset_state: got %h want %h", outs(), 24'h0);
      end else $display("ok   reset_state: %h", outs());
      Reset = 1'b0;
   endtask

   task automatic test_launch();
      Start = 1'b1;
      step();
      Start = 1'b0;
      checks++;
      if ({ProgState, CoreReset, Busy} !== 4'b0111) begin
         errors++;
         $display("FAIL launch_init: got prog=%b cr=%b busy=%b want 01 1 1", ProgState, CoreReset, Busy);
      end else $display("ok   launch_init");
      step();
      checks++;
      if ({CoreReset, Busy, Done} !== 3'b010) begin
         errors++;
         $display("FAIL launch_run: got cr=%b busy=%b done=%b want 0 1 0", CoreReset, Busy, Done);
      end else $display("ok   launch_run");
      Ack = 1'b1;
      step();
      Ack = 1'b0;
      checks++;
      if ({Busy, Done} !== 2'b01) begin
         errors++;
         $display("FAIL launch_done: got busy=%b done=%b want 0 1", Busy, Done);
      end else $display("ok   launch_done");
      step();
      checks++;
      if ({ProgState, Busy, Done, Halt} !== 5'b01000) begin
         errors++;
         $display("FAIL launch_idle: got prog=%b busy=%b done=%b halt=%b want 01 0 0 0", ProgState, Busy, Done, Halt);
      end else $display("ok   launch_idle");
   endtask

   task automatic test_zero_fault();
      Start = 1'b1;
      step();
      Start = 1'b0;
      checks++;
      if (ProgState !== 2'b10) begin
         errors++;
         $display("FAIL zero_prog: got %b want 10", ProgState);
      end else $display("ok   zero_prog");
      step();
      Instruction = 9'h017;
      DataIn = 8'h00;
      step();
      Instruction = 9'h000;
      PC = 10'h067;
      Ack = 1'b1;
      step();
      Ack = 1'b0;
      PC = 10'h000;
      checks++;
      if ({DivZero, Halt, Done, Busy, Timeout} !== 5'b11000) begin
         errors++;
         $display("FAIL zero_fault: got dz=%b halt=%b done=%b busy=%b to=%b want 1 1 0 0 0", DivZero, Halt, Done, Busy, Timeout);
      end else $display("ok   zero_fault");
      Ack = 1'b1;
      step();
      Ack = 1'b0;
      checks++;
      if ({DivZero, Halt, Done} !== 3'b110) begin
         errors++;
         $display("FAIL zero_hold: got dz=%b halt=%b done=%b want 1 1 0", DivZero, Halt, Done);
      end else $display("ok   zero_hold");
      Start = 1'b1;
      step();
      Start = 1'b0;
      checks++;
      if ({ProgState, DivZero, Halt, Busy} !== 5'b10000) begin
         errors++;
         $display("FAIL zero_clear: got prog=%b dz=%b halt=%b busy=%b want 10 0 0 0", ProgState, DivZero, Halt, Busy);
      end else $display("ok   zero_clear");
   endtask

   task automatic test_watchdog();
      int early = 0;
      Start = 1'b1;
      step();
      Start = 1'b0;
      step();
      for (int i = 0; i < 7; i++) begin
         step();
         if (Timeout !== 1'b0 || Busy !== 1'b1) early++;
      end
      checks++;
      if (early != 0) begin
         errors++;
         $display("FAIL watchdog_early: got %0d early cycles want 0", early);
      end else $display("ok   watchdog_early");
      step();
      checks++;
      if ({Timeout, Halt, DivZero, Busy} !== 4'b1100) begin
         errors++;
         $display("FAIL watchdog_fire: got to=%b halt=%b dz=%b busy=%b want 1 1 0 0", Timeout, Halt, DivZero, Busy);
      end else $display("ok   watchdog_fire");
      Start = 1'b1;
      step();
      Start = 1'b0;
      checks++;
      if ({ProgState, Timeout, Halt} !== 4'b1100) begin
         errors++;
         $display("FAIL watchdog_clear: got prog=%b to=%b halt=%b want 11 0 0", ProgState, Timeout, Halt);
      end else $display("ok   watchdog_clear");
   endtask

   task automatic test_capture();
      Start = 1'b1;
      step();
      Start = 1'b0;
      checks++;
      if (ProgState !== 2'b01) begin
         errors++;
         $display("FAIL capture_wrap: got %b want 01", ProgState);
      end else $display("ok   capture_wrap");
      step();
      Instruction = 9'h007;
      DataIn = 8'h12;
      step();
      checks++;
      if (divisor_msb !== 8'h12) begin
         errors++;
         $display("FAIL capture_msb: got %h want 12", divisor_msb);
      end else $display("ok   capture_msb: %h", divisor_msb);
      Instruction = 9'h00F;
      DataIn = 8'h34;
      step();
      checks++;
      if ({divisor_msb, divisor_lsb} !== 16'h1234) begin
         errors++;
         $display("FAIL capture_lsb: got %h want 1234", {divisor_msb, divisor_lsb});
      end else $display("ok   capture_lsb: %h", {divisor_msb, divisor_lsb});
      Instruction = 9'h000;
      PC = 10'h02C;
      step();
      PC = 10'h000;
      checks++;
      if ({DivZero, Halt, Busy} !== 3'b001) begin
         errors++;
         $display("FAIL capture_nofault: got dz=%b halt=%b busy=%b want 0 0 1", DivZero, Halt, Busy);
      end else $display("ok   capture_nofault");
      Ack = 1'b1;
      step();
      Ack = 1'b0;
      step();
   endtask

   task automatic test_wrap_reset();
      logic [1:0] want_prog;
      logic [7:0] want_lsb;
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      for (int p = 1; p <= 3; p++) begin
         want_prog = 2'(p);
         want_lsb  = (p == 1) ? 8'hFF : 8'h00;
         Start = 1'b1;
         step();
         Start = 1'b0;
         checks++;
         if (ProgState !== want_prog) begin
            errors++;
            $display("FAIL wrap_prog%0d: got %b want %b", p, ProgState, want_prog);
         end else $display("ok   wrap_prog%0d", p);
         step();
         Instruction = 9'h00F;
         DataIn = 8'hFF;
         Start = 1'b1;
         step();
         Start = 1'b0;
         Instruction = 9'h000;
         checks++;
         if ({ProgState, divisor_lsb} !== {want_prog, want_lsb}) begin
            errors++;
            $display("FAIL wrap_lsb%0d: got prog=%b lsb=%h want %b %h", p, ProgState, divisor_lsb, want_prog, want_lsb);
         end else $display("ok   wrap_lsb%0d", p);
         PC = (p == 3) ? 10'h067 : 10'h000;
         step();
         PC = 10'h000;
         checks++;
         if ({Halt, DivZero, Busy} !== 3'b001) begin
            errors++;
            $display("FAIL wrap_run%0d: got halt=%b dz=%b busy=%b want 0 0 1", p, Halt, DivZero, Busy);
         end else $display("ok   wrap_run%0d", p);
         Ack = 1'b1;
         step();
         Ack = 1'b0;
         step();
      end
      Start = 1'b1;
      step();
      Start = 1'b0;
      checks++;
      if (ProgState !== 2'b01) begin
         errors++;
         $display("FAIL wrap_to_01: got %b want 01", ProgState);
      end else $display("ok   wrap_to_01");
      step();
      Instruction = 9'h007;
      DataIn = 8'hAB;
      step();
      Reset = 1'b1;
      Ack = 1'b1;
      PC = 10'h02C;
      step();
      Reset = 1'b0;
      Ack = 1'b0;
      PC = 10'h000;
      Instruction = 9'h000;
      checks++;
      if (outs() !== 24'h0) begin
         errors++;
         $display("FAIL midrun_reset: got %h want %h", outs(), 24'h0);
      end else $display("ok   midrun_reset");
   endtask

   initial begin
      test_reset();
      test_launch();
      test_zero_fault();
      test_watchdog();
      test_capture();
      test_wrap_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
